// File: rtl/logic_issue_seq_pkg.sv
// Shared types and opcode decode for the vector logic sequencer.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package vect_pkg;

  // Opcode layout is {funct6, group}. Group 0 is INT (OPIV*), group 1 is MULT (OPMVV).
  localparam logic       GRP_INT    = 1'b0;
  localparam logic [5:0] F6_VAND    = 6'b001001;
  localparam logic [5:0] F6_VOR     = 6'b001010;
  localparam logic [5:0] F6_VXOR    = 6'b001011;
  // Mask-logical ops (vmandn..vmxnor) occupy funct6 6'b011xxx in the MULT group.
  localparam logic [2:0] F6_MASK_HI = 3'b011;

  // VADD INT encoding: never decoded as a logic op, so the unit stays gated.
  localparam logic [6:0] LOGIC_NOP  = 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  function automatic logic is_logic_op(input logic [6:0] ocode);
    logic [5:0] f6;
    logic       ok;
    f6 = ocode[6:1];
    if (ocode[0] == GRP_INT) begin
      ok = (f6 == F6_VAND) || (f6 == F6_VOR) || (f6 == F6_VXOR);
    end else begin
      ok = (f6[5:3] == F6_MASK_HI);
    end
    return ok;
  endfunction

endpackage

// File: rtl/logic_issue_seq_pipe_stage.sv
// EX->WB register holding the captured logic-unit result with its element index.
// Latency: 1 cycle.
// Backpressure: none; flush drops the in-flight element.
module logic_pipe_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int VL_W       = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_vld,
  input  logic                  in_last,
  input  logic [VL_W-1:0]       in_idx,
  input  logic [DATA_WIDTH-1:0] in_dat,
  output logic                  out_vld,
  output logic                  out_last,
  output logic [VL_W-1:0]       out_idx,
  output logic [DATA_WIDTH-1:0] out_dat
);

  // Capture valid/last/index/data each cycle; flush kills the valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_idx  <= '0;
      out_dat  <= '0;
    end else begin
      out_vld  <= in_vld & ~flush;
      out_last <= in_last;
      out_idx  <= in_idx;
      out_dat  <= in_dat;
    end
  end

endmodule

// File: rtl/logic_issue_seq.sv
// Element sequencer feeding the vector logic unit: VRF read -> EX -> WB, one element per cycle.
// Latency: accept at cycle 0, first write at cycle 3, last write and done at cycle vl+2.
// Backpressure: instr_ready_o only in IDLE without flush; no stalls once an instruction is issued.
module logic_issue_seq
  import vect_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_VL     = 32,
  parameter int VL_W       = $clog2(MAX_VL + 1),
  parameter int REG_AW     = 5
) (
  input  logic                  module_clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [6:0]            instr_ocode_i,
  input  logic [REG_AW-1:0]     instr_vd_i,
  input  logic [REG_AW-1:0]     instr_vs1_i,
  input  logic [REG_AW-1:0]     instr_vs2_i,
  input  logic [VL_W-1:0]       instr_vl_i,
  input  logic                  instr_scalar_en_i,
  input  logic [DATA_WIDTH-1:0] instr_scalar_i,
  output logic                  rf_rd_en_o,
  output logic [REG_AW-1:0]     rf_rd_reg1_o,
  output logic [REG_AW-1:0]     rf_rd_reg2_o,
  output logic [VL_W-1:0]       rf_rd_idx_o,
  input  logic [DATA_WIDTH-1:0] rf_rd_data1_i,
  input  logic [DATA_WIDTH-1:0] rf_rd_data2_i,
  output logic                  alu_e_o,
  output logic [6:0]            alu_ocode_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  output logic                  rf_wr_en_o,
  output logic [REG_AW-1:0]     rf_wr_reg_o,
  output logic [VL_W-1:0]       rf_wr_idx_o,
  output logic [DATA_WIDTH-1:0] rf_wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  seq_state_e            state_q, state_d;
  logic                  run_q;
  logic [6:0]            ocode_q;
  logic [REG_AW-1:0]     vd_q, vs1_q, vs2_q;
  logic [VL_W-1:0]       vl_q, rd_idx_q, vl_clip;
  logic                  scalar_en_q;
  logic [DATA_WIDTH-1:0] scalar_q;
  logic                  accept, acc_legal, acc_issue, last_rd;
  logic                  imm_done_q, imm_err_q;
  logic                  ex_vld_q, ex_last_q;
  logic [VL_W-1:0]       ex_idx_q;
  logic [DATA_WIDTH-1:0] a_hold_q, b_hold_q, b_sel;
  logic                  wb_vld, wb_last;
  logic [VL_W-1:0]       wb_idx;
  logic [DATA_WIDTH-1:0] wb_dat;

  // run_q keeps ready low while reset is held so every output reads 0 in reset.
  assign instr_ready_o = run_q & (state_q == IDLE) & ~flush_i;
  assign accept        = instr_valid_i & instr_ready_o;
  assign vl_clip       = (instr_vl_i > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : instr_vl_i;
  assign acc_legal     = is_logic_op(instr_ocode_i);
  assign acc_issue     = accept & acc_legal & (vl_clip != '0);
  assign last_rd       = (rd_idx_q == vl_q - VL_W'(1));
  assign b_sel         = scalar_en_q ? scalar_q : rf_rd_data1_i;

  // Next-state: issue reads until the last index, drain until the last write retires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc_issue) state_d = ISSUE;
      ISSUE:   if (last_rd) state_d = DRAIN;
      DRAIN:   if (wb_vld && wb_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // State register plus the out-of-reset flag gating instr_ready_o.
  always_ff @(posedge module_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Latch the instruction fields on accept; vl is clipped to MAX_VL here.
  always_ff @(posedge module_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ocode_q     <= LOGIC_NOP;
      vd_q        <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      vl_q        <= '0;
      scalar_en_q <= 1'b0;
      scalar_q    <= '0;
    end else if (accept) begin
      ocode_q     <= instr_ocode_i;
      vd_q        <= instr_vd_i;
      vs1_q       <= instr_vs1_i;
      vs2_q       <= instr_vs2_i;
      vl_q        <= vl_clip;
      scalar_en_q <= instr_scalar_en_i;
      scalar_q    <= instr_scalar_i;
    end
  end

  // Read index counter and the one-cycle completion pulse for vl=0 / illegal opcodes.
  always_ff @(posedge module_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_idx_q   <= '0;
      imm_done_q <= 1'b0;
      imm_err_q  <= 1'b0;
    end else begin
      if (accept) rd_idx_q <= '0;
      else if (state_q == ISSUE) rd_idx_q <= rd_idx_q + VL_W'(1);
      imm_done_q <= accept & ~acc_issue;
      imm_err_q  <= accept & ~acc_legal;
    end
  end

  // EX stage tracks which read is returning this cycle.
  always_ff @(posedge module_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_vld_q  <= 1'b0;
      ex_last_q <= 1'b0;
      ex_idx_q  <= '0;
    end else begin
      ex_vld_q  <= (state_q == ISSUE) & ~flush_i;
      ex_last_q <= last_rd;
      ex_idx_q  <= rd_idx_q;
    end
  end

  // Operand hold so the unit inputs stay still while it is disabled.
  always_ff @(posedge module_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else if (ex_vld_q) begin
      a_hold_q <= rf_rd_data2_i;
      b_hold_q <= b_sel;
    end
  end

  assign alu_e_o     = ex_vld_q;
  assign alu_ocode_o = ex_vld_q ? ocode_q : LOGIC_NOP;
  assign alu_a_o     = ex_vld_q ? rf_rd_data2_i : a_hold_q;
  assign alu_b_o     = ex_vld_q ? b_sel : b_hold_q;

  logic_pipe_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .VL_W      (VL_W)
  ) u_wb (
    .clk     (module_clk_i),
    .rst_n   (rst_ni),
    .flush   (flush_i),
    .in_vld  (ex_vld_q),
    .in_last (ex_last_q),
    .in_idx  (ex_idx_q),
    .in_dat  (alu_result_i),
    .out_vld (wb_vld),
    .out_last(wb_last),
    .out_idx (wb_idx),
    .out_dat (wb_dat)
  );

  assign rf_rd_en_o   = (state_q == ISSUE);
  assign rf_rd_reg1_o = vs1_q;
  assign rf_rd_reg2_o = vs2_q;
  assign rf_rd_idx_o  = rd_idx_q;
  assign rf_wr_en_o   = wb_vld;
  assign rf_wr_reg_o  = vd_q;
  assign rf_wr_idx_o  = wb_idx;
  assign rf_wr_data_o = wb_dat;
  // A flush landing on the final write cancels the completion of that instruction.
  assign done_o       = (wb_vld & wb_last & ~flush_i) | imm_done_q;
  assign err_o        = imm_err_q;
  assign busy_o       = (state_q != IDLE) | imm_done_q;

endmodule

// File: tb/tb_logic_issue_seq.sv
module tb_logic_issue_seq;
  import vect_pkg::*;

  localparam int DW = 32;
  localparam int VLW = 6;

  logic module_clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i = 1'b0;
  logic instr_valid_i = 1'b0;
  logic instr_ready_o;
  logic [6:0] instr_ocode_i = '0;
  logic [4:0] instr_vd_i = '0, instr_vs1_i = '0, instr_vs2_i = '0;
  logic [VLW-1:0] instr_vl_i = '0;
  logic instr_scalar_en_i = 1'b0;
  logic [DW-1:0] instr_scalar_i = '0;
  logic rf_rd_en_o;
  logic [4:0] rf_rd_reg1_o, rf_rd_reg2_o;
  logic [VLW-1:0] rf_rd_idx_o;
  logic [DW-1:0] rf_rd_data1_i = '0, rf_rd_data2_i = '0;
  logic alu_e_o;
  logic [6:0] alu_ocode_o;
  logic [DW-1:0] alu_a_o, alu_b_o, alu_result_i;
  logic rf_wr_en_o;
  logic [4:0] rf_wr_reg_o;
  logic [VLW-1:0] rf_wr_idx_o;
  logic [DW-1:0] rf_wr_data_o;
  logic busy_o, done_o, err_o;

  always #5 module_clk_i = ~module_clk_i;

  logic_issue_seq dut (
    .module_clk_i(module_clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_ocode_i(instr_ocode_i), .instr_vd_i(instr_vd_i),
    .instr_vs1_i(instr_vs1_i), .instr_vs2_i(instr_vs2_i), .instr_vl_i(instr_vl_i),
    .instr_scalar_en_i(instr_scalar_en_i), .instr_scalar_i(instr_scalar_i),
    .rf_rd_en_o(rf_rd_en_o), .rf_rd_reg1_o(rf_rd_reg1_o), .rf_rd_reg2_o(rf_rd_reg2_o),
    .rf_rd_idx_o(rf_rd_idx_o), .rf_rd_data1_i(rf_rd_data1_i), .rf_rd_data2_i(rf_rd_data2_i),
    .alu_e_o(alu_e_o), .alu_ocode_o(alu_ocode_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .rf_wr_en_o(rf_wr_en_o), .rf_wr_reg_o(rf_wr_reg_o),
    .rf_wr_idx_o(rf_wr_idx_o), .rf_wr_data_o(rf_wr_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // Logical semantics of each RVV logic opcode ({funct6, group}); a = vs2, b = vs1/scalar.
  function automatic logic [31:0] alu_ref(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      7'h12, 7'h33: return a & b;
      7'h14, 7'h35: return a | b;
      7'h16, 7'h37: return a ^ b;
      7'h31:        return a & ~b;
      7'h39:        return a | ~b;
      7'h3B:        return ~(a & b);
      7'h3D:        return ~(a | b);
      7'h3F:        return ~(a ^ b);
      default:      return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic bit tb_legal(input logic [6:0] op);
    return op inside {7'h12, 7'h14, 7'h16, 7'h31, 7'h33, 7'h35, 7'h37, 7'h39, 7'h3B, 7'h3D, 7'h3F};
  endfunction

  assign alu_result_i = alu_ref(alu_ocode_o, alu_a_o, alu_b_o);

  // Behavioural VRF: read data appears one cycle after the strobe, garbage otherwise.
  logic [31:0] vrf [32][32];
  always @(posedge module_clk_i) begin
    if (rf_rd_en_o) begin
      rf_rd_data1_i <= vrf[rf_rd_reg1_o][rf_rd_idx_o[4:0]];
      rf_rd_data2_i <= vrf[rf_rd_reg2_o][rf_rd_idx_o[4:0]];
    end else begin
      rf_rd_data1_i <= $urandom;
      rf_rd_data2_i <= $urandom;
    end
  end

  typedef struct packed {
    logic [31:0] c;
    logic [4:0]  r;
    logic [5:0]  i;
    logic [31:0] d;
  } wr_t;

  int cyc = 0;
  always @(posedge module_clk_i) cyc <= cyc + 1;

  // Observed-event logs, appended only by this monitor.
  wr_t wr_q[$];
  int done_q[$];
  int err_q[$];
  logic [6:0] ae_ops[$];
  int rd_cnt = 0;
  int nop_bad = 0;
  wr_t mon_w;
  always @(negedge module_clk_i) begin
    if (rst_ni) begin
      if (rf_wr_en_o) begin
        mon_w = '{c: cyc, r: rf_wr_reg_o, i: rf_wr_idx_o, d: rf_wr_data_o};
        wr_q.push_back(mon_w);
      end
      if (done_o) done_q.push_back(cyc);
      if (err_o) err_q.push_back(cyc);
      if (rf_rd_en_o) rd_cnt++;
      if (alu_e_o) ae_ops.push_back(alu_ocode_o);
      else if (alu_ocode_o !== LOGIC_NOP) nop_bad++;
    end
  end

  logic [129:0] outs;
  assign outs = {instr_ready_o, rf_rd_en_o, rf_rd_reg1_o, rf_rd_reg2_o, rf_rd_idx_o, alu_e_o,
                 alu_a_o, alu_b_o, rf_wr_en_o, rf_wr_reg_o, rf_wr_idx_o, rf_wr_data_o,
                 busy_o, done_o, err_o};

  int nvec = 0;
  int nerr = 0;
  wr_t exp_q[$];
  int exp_done_q[$];
  bit exp_err;

  // Expected writes/done for one instruction, appended to exp_q / exp_done_q.
  task automatic model(input logic [6:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                       input logic [4:0] vs2, input int vl, input bit sen, input logic [31:0] sc,
                       input int acc);
    int n;
    wr_t w;
    n = tb_legal(op) ? ((vl > 32) ? 32 : vl) : 0;
    for (int i = 0; i < n; i++) begin
      w.c = acc + 3 + i;
      w.r = vd;
      w.i = 6'(i);
      w.d = alu_ref(op, vrf[vs2][i], sen ? sc : vrf[vs1][i]);
      exp_q.push_back(w);
    end
    exp_done_q.push_back((n == 0) ? acc + 1 : acc + 2 + n);
    exp_err = !tb_legal(op);
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                      input logic [4:0] vs2, input int vl, input bit sen, input logic [31:0] sc,
                      output int acc);
    bit got;
    got = 0;
    acc = -100;
    @(negedge module_clk_i); #1;
    instr_ocode_i = op; instr_vd_i = vd; instr_vs1_i = vs1; instr_vs2_i = vs2;
    instr_vl_i = 6'(vl); instr_scalar_en_i = sen; instr_scalar_i = sc; instr_valid_i = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      if (instr_ready_o) begin
        got = 1;
        acc = cyc;
      end else begin
        @(negedge module_clk_i); #1;
      end
    end
    @(posedge module_clk_i); #1;
    instr_valid_i = 1'b0;
    nvec++;
    if (!got) begin
      nerr++;
      $display("FAIL accept_timeout: instr_ready_o never seen, got 0 required 1");
    end
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge module_clk_i); #1;
      if (done_q.size() >= target) ok = 1;
    end
    repeat (3) @(negedge module_clk_i);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge module_clk_i);
    #1;
    nvec++;
    if (outs !== '0) begin nerr++; $display("FAIL reset_outputs: got %h required 0", outs); end
    nvec++;
    if (alu_ocode_o !== LOGIC_NOP) begin nerr++; $display("FAIL reset_ocode: got %h required %h", alu_ocode_o, LOGIC_NOP); end
    rst_ni = 1'b1;
    repeat (3) @(negedge module_clk_i);
    #1;
    nvec++;
    if (instr_ready_o !== 1'b1) begin nerr++; $display("FAIL ready_after_reset: got %b required 1", instr_ready_o); end
  endtask

  task automatic test_vand();
    int acc, wb, db;
    bit ok;
    vrf[2][0] = 32'hF0F0_F0F0; vrf[2][1] = 32'hFFFF_0000; vrf[2][2] = 32'h1234_5678; vrf[2][3] = 32'h0;
    for (int i = 0; i < 4; i++) vrf[1][i] = 32'h0F0F_FFFF;
    wb = wr_q.size(); db = done_q.size();
    exp_q.delete(); exp_done_q.delete();
    send(7'h12, 5'd3, 5'd1, 5'd2, 4, 1'b0, 32'h0, acc);
    model(7'h12, 5'd3, 5'd1, 5'd2, 4, 1'b0, 32'h0, acc);
    wait_done(db + 1, ok);
    nvec++;
    if (!ok || wr_q.size() - wb != 4) begin
      nerr++; $display("FAIL vand_count: got %0d writes required 4 (done seen %b)", wr_q.size() - wb, ok);
    end else begin
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (wr_q[wb + k] !== exp_q[k]) begin nerr++; $display("FAIL vand_wr%0d: got %h required %h", k, wr_q[wb + k], exp_q[k]); end
      end
      nvec++;
      if (done_q[db] !== acc + 6) begin nerr++; $display("FAIL vand_done: got cycle %0d required %0d", done_q[db], acc + 6); end
    end
  endtask

  task automatic test_scalar_xnor();
    int acc, wb, db, ab, nb;
    bit ok;
    vrf[4][0] = 32'h0000_00FF;
    wb = wr_q.size(); db = done_q.size(); ab = ae_ops.size(); nb = nop_bad;
    exp_q.delete(); exp_done_q.delete();
    send(7'h3F, 5'd5, 5'd6, 5'd4, 1, 1'b1, 32'h0000_FFFF, acc);
    model(7'h3F, 5'd5, 5'd6, 5'd4, 1, 1'b1, 32'h0000_FFFF, acc);
    wait_done(db + 1, ok);
    nvec++;
    if (!ok || wr_q.size() - wb != 1 || wr_q[wb] !== exp_q[0])
      begin nerr++; $display("FAIL xnor_write: got %0d writes first %h required 1 write %h", wr_q.size() - wb, (wr_q.size() > wb) ? wr_q[wb] : '0, exp_q[0]); end
    nvec++;
    if (ae_ops.size() - ab != 1 || ae_ops[ab] !== 7'h3F)
      begin nerr++; $display("FAIL xnor_alu_e: got %0d enables op %h required 1 enable op 3f", ae_ops.size() - ab, (ae_ops.size() > ab) ? ae_ops[ab] : 7'h0); end
    nvec++;
    if (nop_bad != nb) begin nerr++; $display("FAIL xnor_nop: got %0d non-NOP idle cycles required 0", nop_bad - nb); end
    nvec++;
    if (done_q[db] !== exp_done_q[0]) begin nerr++; $display("FAIL xnor_done: got %0d required %0d", done_q[db], exp_done_q[0]); end
  endtask

  task automatic test_back_to_back();
    int acc_a, acc_b, wb, db;
    bit ok;
    for (int i = 0; i < 32; i++) begin vrf[7][i] = $urandom; vrf[8][i] = $urandom; end
    wb = wr_q.size(); db = done_q.size();
    exp_q.delete(); exp_done_q.delete();
    send(7'h14, 5'd9, 5'd7, 5'd8, 2, 1'b0, 32'h0, acc_a);
    send(7'h37, 5'd7, 5'd7, 5'd8, 2, 1'b0, 32'h0, acc_b);
    model(7'h14, 5'd9, 5'd7, 5'd8, 2, 1'b0, 32'h0, acc_a);
    model(7'h37, 5'd7, 5'd7, 5'd8, 2, 1'b0, 32'h0, acc_b);
    wait_done(db + 2, ok);
    nvec++;
    if (acc_b != exp_done_q[0] + 1) begin nerr++; $display("FAIL b2b_accept: got cycle %0d required %0d", acc_b, exp_done_q[0] + 1); end
    nvec++;
    if (!ok || wr_q.size() - wb != 4) begin
      nerr++; $display("FAIL b2b_count: got %0d writes required 4", wr_q.size() - wb);
    end else begin
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (wr_q[wb + k] !== exp_q[k]) begin nerr++; $display("FAIL b2b_wr%0d: got %h required %h", k, wr_q[wb + k], exp_q[k]); end
      end
      nvec++;
      if (done_q[db + 1] !== exp_done_q[1]) begin nerr++; $display("FAIL b2b_done: got %0d required %0d", done_q[db + 1], exp_done_q[1]); end
    end
  endtask

  task automatic test_vl0_illegal();
    int acc, wb, db, eb, rb;
    bit ok;
    for (int c = 0; c < 2; c++) begin
      logic [6:0] op;
      op = (c == 0) ? 7'h16 : 7'h7F;
      wb = wr_q.size(); db = done_q.size(); eb = err_q.size(); rb = rd_cnt;
      exp_q.delete(); exp_done_q.delete();
      send(op, 5'd10, 5'd1, 5'd2, (c == 0) ? 0 : 5, 1'b0, 32'h0, acc);
      model(op, 5'd10, 5'd1, 5'd2, (c == 0) ? 0 : 5, 1'b0, 32'h0, acc);
      wait_done(db + 1, ok);
      nvec++;
      if (!ok || done_q[db] !== exp_done_q[0]) begin nerr++; $display("FAIL imm_done%0d: got %0d required %0d", c, ok ? done_q[db] : -1, exp_done_q[0]); end
      nvec++;
      if (err_q.size() - eb != int'(exp_err)) begin nerr++; $display("FAIL imm_err%0d: got %0d pulses required %0d", c, err_q.size() - eb, exp_err); end
      nvec++;
      if (wr_q.size() != wb || rd_cnt != rb) begin nerr++; $display("FAIL imm_access%0d: got %0d writes %0d reads required 0 0", c, wr_q.size() - wb, rd_cnt - rb); end
    end
  endtask

  task automatic test_clip();
    int acc, wb, db;
    bit ok;
    for (int i = 0; i < 32; i++) begin vrf[11][i] = $urandom; vrf[12][i] = $urandom; end
    wb = wr_q.size(); db = done_q.size();
    exp_q.delete(); exp_done_q.delete();
    send(7'h3B, 5'd13, 5'd11, 5'd12, 40, 1'b0, 32'h0, acc);
    model(7'h3B, 5'd13, 5'd11, 5'd12, 40, 1'b0, 32'h0, acc);
    wait_done(db + 1, ok);
    nvec++;
    if (!ok || wr_q.size() - wb != 32) begin
      nerr++; $display("FAIL clip_count: got %0d writes required 32", wr_q.size() - wb);
    end else begin
      for (int k = 0; k < 32; k++) begin
        nvec++;
        if (wr_q[wb + k] !== exp_q[k]) begin nerr++; $display("FAIL clip_wr%0d: got %h required %h", k, wr_q[wb + k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_flush();
    int acc, wb, db;
    for (int i = 0; i < 32; i++) begin vrf[14][i] = $urandom; vrf[15][i] = $urandom; end
    wb = wr_q.size(); db = done_q.size();
    exp_q.delete(); exp_done_q.delete();
    send(7'h16, 5'd16, 5'd14, 5'd15, 8, 1'b0, 32'h0, acc);
    model(7'h16, 5'd16, 5'd14, 5'd15, 8, 1'b0, 32'h0, acc);
    while (cyc < acc + 4) begin @(negedge module_clk_i); #1; end
    flush_i = 1'b1;
    @(negedge module_clk_i); #1;
    flush_i = 1'b0;
    nvec++;
    if (busy_o !== 1'b0) begin nerr++; $display("FAIL flush_busy: got %b required 0", busy_o); end
    repeat (12) @(negedge module_clk_i);
    #1;
    nvec++;
    if (wr_q.size() - wb != 2) begin
      nerr++; $display("FAIL flush_count: got %0d writes required 2", wr_q.size() - wb);
    end else begin
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (wr_q[wb + k] !== exp_q[k]) begin nerr++; $display("FAIL flush_wr%0d: got %h required %h", k, wr_q[wb + k], exp_q[k]); end
      end
    end
    nvec++;
    if (done_q.size() != db) begin nerr++; $display("FAIL flush_done: got %0d pulses required 0", done_q.size() - db); end
  endtask

  task automatic test_async_reset();
    int acc, db;
    db = done_q.size();
    send(7'h35, 5'd17, 5'd14, 5'd15, 8, 1'b0, 32'h0, acc);
    while (cyc < acc + 3) begin @(negedge module_clk_i); #1; end
    rst_ni = 1'b0;
    #1;
    nvec++;
    if (outs !== '0) begin nerr++; $display("FAIL areset_outputs: got %h required 0", outs); end
    nvec++;
    if (alu_ocode_o !== LOGIC_NOP) begin nerr++; $display("FAIL areset_ocode: got %h required %h", alu_ocode_o, LOGIC_NOP); end
    @(negedge module_clk_i); #1;
    rst_ni = 1'b1;
    repeat (12) @(negedge module_clk_i);
    #1;
    nvec++;
    if (done_q.size() != db) begin nerr++; $display("FAIL areset_done: got %0d pulses required 0", done_q.size() - db); end
  endtask

  task automatic test_random();
    logic [6:0] ops [13] = '{7'h12, 7'h14, 7'h16, 7'h31, 7'h33, 7'h35, 7'h37,
                             7'h39, 7'h3B, 7'h3D, 7'h3F, 7'h7F, 7'h00};
    int acc, wb, db, eb, rb, vl, nb;
    logic [6:0] op;
    logic [4:0] vd, vs1, vs2;
    logic [31:0] sc;
    bit sen, ok;
    for (int r = 0; r < 32; r++) for (int i = 0; i < 32; i++) vrf[r][i] = $urandom;
    nb = nop_bad;
    for (int n = 0; n < 24; n++) begin
      op = ops[$urandom_range(0, 12)];
      vd = 5'($urandom); vs1 = 5'($urandom); vs2 = 5'($urandom);
      if (n % 4 == 0) vd = vs1;
      vl = $urandom_range(0, 40); sen = 1'($urandom_range(0, 1)); sc = $urandom;
      wb = wr_q.size(); db = done_q.size(); eb = err_q.size(); rb = rd_cnt;
      exp_q.delete(); exp_done_q.delete();
      send(op, vd, vs1, vs2, vl, sen, sc, acc);
      model(op, vd, vs1, vs2, vl, sen, sc, acc);
      wait_done(db + 1, ok);
      nvec++;
      if (!ok || done_q[db] !== exp_done_q[0]) begin
        nerr++; $display("FAIL rnd%0d_done: op %h vl %0d got %0d required %0d", n, op, vl, ok ? done_q[db] : -1, exp_done_q[0]);
      end
      nvec++;
      if (wr_q.size() - wb != exp_q.size() || rd_cnt - rb != exp_q.size()) begin
        nerr++; $display("FAIL rnd%0d_count: got %0d writes %0d reads required %0d", n, wr_q.size() - wb, rd_cnt - rb, exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          nvec++;
          if (wr_q[wb + k] !== exp_q[k]) begin nerr++; $display("FAIL rnd%0d_wr%0d: got %h required %h", n, k, wr_q[wb + k], exp_q[k]); end
        end
      end
      nvec++;
      if (err_q.size() - eb != int'(exp_err)) begin nerr++; $display("FAIL rnd%0d_err: got %0d required %0d", n, err_q.size() - eb, exp_err); end
    end
    nvec++;
    if (nop_bad != nb) begin nerr++; $display("FAIL rnd_nop: got %0d non-NOP idle cycles required 0", nop_bad - nb); end
  endtask

  initial begin
    test_reset();
    test_vand();
    test_scalar_xnor();
    test_back_to_back();
    test_vl0_illegal();
    test_clip();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
